// File: rtl/add_pkg.sv
// Shared types for the operand pairing front end of the add/sub stage.
package add_pkg;

  localparam int OPERAND_W = 8;

  typedef logic [OPERAND_W-1:0] operand_t;

  typedef struct packed {
    operand_t a;
    operand_t b;
  } pair_t;

  typedef enum logic {
    WAIT_A = 1'b0,
    WAIT_B = 1'b1
  } pair_state_t;

  function automatic pair_t make_pair(input operand_t a, input operand_t b);
    pair_t p;
    p.a = a;
    p.b = b;
    return p;
  endfunction

endpackage

// File: rtl/operand_pair_buffer_fifo.sv
// First-word-fall-through FIFO with explicit occupancy count and synchronous flush.
// Head entry is visible on pop_dat whenever count is non-zero; flush overrides push/pop.
module sync_fifo_fwft
  import add_pkg::*;
#(
  parameter int  WIDTH  = 16,
  parameter int  DEPTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [WIDTH-1:0]  push_dat,
  input  logic              pop,
  output logic [WIDTH-1:0]  pop_dat,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              w_push;
  logic              w_pop;

  assign w_push = push & ~flush;
  assign w_pop  = pop & ~flush;

  // Storage is deliberately left without reset; count alone decides validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign pop_dat = r_mem[r_rd_ptr];
  assign count   = r_count;

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n) w_push |-> (r_count != FULL_CNT));

  a_no_underflow: assert property (
    @(posedge clk) disable iff (!rst_n) w_pop |-> (r_count != '0));

endmodule

// File: rtl/operand_pair_buffer.sv
// Pairs a serial byte stream into (add1, add2) operands and queues them for the add/sub stage.
// Pair visible one cycle after its second byte; in_ready drops only when a second byte meets a full FIFO.
module operand_pair_buffer
  import add_pkg::*;
#(
  parameter int  DATA_W = 8,
  parameter int  DEPTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              pair_valid,
  input  logic              pair_ready,
  output logic [DATA_W-1:0] add1,
  output logic [DATA_W-1:0] add2,
  output logic [ADDR_W:0]   count,
  output logic              half_held
);

  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

  pair_state_t         r_state;
  logic [DATA_W-1:0]   r_hold;
  logic                r_half_held;

  logic                w_accept;
  logic                w_push;
  logic                w_pop;
  logic [2*DATA_W-1:0] w_head;
  logic [ADDR_W:0]     w_count;

  // The first byte of a pair always fits in the hold register, so only the
  // second byte ever waits on FIFO space; pair_ready never reaches in_ready.
  assign in_ready = (r_state == WAIT_A) || (w_count != FULL_CNT);
  assign w_accept = in_valid & in_ready;
  assign w_push   = w_accept & (r_state == WAIT_B) & ~flush;
  assign w_pop    = pair_valid & pair_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= WAIT_A;
      r_hold      <= '0;
      r_half_held <= 1'b0;
    end else if (flush) begin
      r_state     <= WAIT_A;
      r_half_held <= 1'b0;
    end else if (w_accept) begin
      unique case (r_state)
        WAIT_A: begin
          r_hold      <= in_data;
          r_state     <= WAIT_B;
          r_half_held <= 1'b1;
        end
        WAIT_B: begin
          r_state     <= WAIT_A;
          r_half_held <= 1'b0;
        end
      endcase
    end
  end

  sync_fifo_fwft #(
    .WIDTH (2*DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push     (w_push),
    .push_dat ({r_hold, in_data}),
    .pop      (w_pop),
    .pop_dat  (w_head),
    .count    (w_count)
  );

  assign pair_valid = (w_count != '0);
  assign add1       = pair_valid ? w_head[2*DATA_W-1:DATA_W] : '0;
  assign add2       = pair_valid ? w_head[DATA_W-1:0]        : '0;
  assign count      = w_count;
  assign half_held  = r_half_held;

endmodule

// File: tb/tb_operand_pair_buffer.sv
// Directed self-checking bench for operand_pair_buffer: pairing, fill/stall, wrap, flush, async reset.
module tb_operand_pair_buffer;
  import add_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       pair_valid;
  logic       pair_ready;
  logic [7:0] add1;
  logic [7:0] add2;
  logic [2:0] count;
  logic       half_held;

  int n_checks = 0;
  int n_fail   = 0;

  operand_pair_buffer #(.DATA_W(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .pair_valid (pair_valid),
    .pair_ready (pair_ready),
    .add1       (add1),
    .add2       (add2),
    .count      (count),
    .half_held  (half_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count_during: got %0d expected 0", count); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready_during: got %b expected 1", in_ready); end
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    cycle();
    n_checks++; if (pair_valid !== 1'b0) begin n_fail++; $display("FAIL idle_pair_valid: got %b expected 0", pair_valid); end
    n_checks++; if (add1 !== 8'h00 || add2 !== 8'h00) begin n_fail++; $display("FAIL idle_operands: got %h/%h expected 00/00", add1, add2); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL idle_count: got %0d expected 0", count); end
    n_checks++; if (half_held !== 1'b0) begin n_fail++; $display("FAIL idle_half_held: got %b expected 0", half_held); end
  endtask

  task automatic test_single_pair();
    pair_ready = 1'b1;
    in_valid   = 1'b1;
    in_data    = 8'h12;
    cycle();
    n_checks++; if (half_held !== 1'b1) begin n_fail++; $display("FAIL single_half_held: got %b expected 1", half_held); end
    n_checks++; if (pair_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b expected 0", pair_valid); end
    in_data = 8'h34;
    cycle();
    in_valid = 1'b0;
    n_checks++; if (pair_valid !== 1'b1) begin n_fail++; $display("FAIL single_pair_valid: got %b expected 1", pair_valid); end
    n_checks++; if (add1 !== 8'h12 || add2 !== 8'h34) begin n_fail++; $display("FAIL single_operands: got %h/%h expected 12/34", add1, add2); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", count); end
    cycle();
    n_checks++; if (count !== 3'd0 || pair_valid !== 1'b0) begin n_fail++; $display("FAIL single_popped: got count %0d valid %b expected 0/0", count, pair_valid); end
    pair_ready = 1'b0;
  endtask

  task automatic test_fill_stall();
    logic [7:0] exp_a [5];
    logic [7:0] exp_b [5];
    for (int k = 0; k < 5; k++) begin
      exp_a[k] = 8'(2*k + 1);
      exp_b[k] = 8'(2*k + 2);
    end
    pair_ready = 1'b0;
    for (int b = 1; b <= 9; b++) begin
      in_valid = 1'b1;
      in_data  = 8'(b);
      cycle();
    end
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d expected 4", count); end
    n_checks++; if (half_held !== 1'b1) begin n_fail++; $display("FAIL fill_half_held: got %b expected 1", half_held); end
    in_data = 8'h0A;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_stall_ready: got %b expected 0", in_ready); end
    cycle();
    n_checks++; if (count !== 3'd4 || half_held !== 1'b1) begin n_fail++; $display("FAIL fill_stall_hold: got count %0d half %b expected 4/1", count, half_held); end
    pair_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++; if (pair_valid !== 1'b1 || add1 !== exp_a[k] || add2 !== exp_b[k]) begin
        n_fail++; $display("FAIL drain_pair%0d: got v%b %h/%h expected v1 %h/%h", k, pair_valid, add1, add2, exp_a[k], exp_b[k]);
      end
      if (k == 1) begin
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL drain_ready_reopen: got %b expected 1", in_ready); end
      end
      cycle();
      if (k == 1) in_valid = 1'b0;
    end
    n_checks++; if (count !== 3'd0 || pair_valid !== 1'b0 || half_held !== 1'b0) begin
      n_fail++; $display("FAIL drain_empty: got count %0d valid %b half %b expected 0/0/0", count, pair_valid, half_held);
    end
    pair_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    pair_t      exp_q[$];
    logic [7:0] prev;
    pair_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h21 + b);
      cycle();
    end
    exp_q.push_back(make_pair(8'h21, 8'h22));
    exp_q.push_back(make_pair(8'h23, 8'h24));
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_start_count: got %0d expected 2", count); end
    prev = 8'h00;
    for (int i = 0; i < 8; i++) begin
      in_valid   = 1'b1;
      in_data    = 8'(8'h25 + i);
      pair_ready = (i % 2 == 1);
      #1;
      if (pair_ready) begin
        n_checks++; if (add1 !== exp_q[0].a || add2 !== exp_q[0].b) begin
          n_fail++; $display("FAIL b2b_head%0d: got %h/%h expected %h/%h", i, add1, add2, exp_q[0].a, exp_q[0].b);
        end
      end
      cycle();
      if (pair_ready) void'(exp_q.pop_front());
      if (i % 2 == 1) exp_q.push_back(make_pair(prev, in_data));
      prev = in_data;
      n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_count%0d: got %0d expected 2", i, count); end
    end
    in_valid   = 1'b0;
    pair_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks++; if (pair_valid !== 1'b1 || add1 !== exp_q[0].a || add2 !== exp_q[0].b) begin
        n_fail++; $display("FAIL b2b_tail%0d: got v%b %h/%h expected v1 %h/%h", k, pair_valid, add1, add2, exp_q[0].a, exp_q[0].b);
      end
      cycle();
      void'(exp_q.pop_front());
    end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL b2b_end_count: got %0d expected 0", count); end
    pair_ready = 1'b0;
  endtask

  task automatic test_flush();
    pair_ready = 1'b0;
    for (int b = 0; b < 7; b++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h41 + b);
      cycle();
    end
    n_checks++; if (count !== 3'd3 || half_held !== 1'b1) begin n_fail++; $display("FAIL flush_pre: got count %0d half %b expected 3/1", count, half_held); end
    flush      = 1'b1;
    in_valid   = 1'b1;
    in_data    = 8'h99;
    pair_ready = 1'b1;
    cycle();
    flush      = 1'b0;
    in_valid   = 1'b0;
    pair_ready = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0 || half_held !== 1'b0 || pair_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_clear: got count %0d half %b valid %b expected 0/0/0", count, half_held, pair_valid);
    end
    n_checks++; if (add1 !== 8'h00 || add2 !== 8'h00) begin n_fail++; $display("FAIL flush_operands: got %h/%h expected 00/00", add1, add2); end
    in_valid = 1'b1;
    in_data  = 8'hAA;
    cycle();
    in_data  = 8'hBB;
    cycle();
    in_valid = 1'b0;
    n_checks++; if (pair_valid !== 1'b1 || add1 !== 8'hAA || add2 !== 8'hBB || count !== 3'd1) begin
      n_fail++; $display("FAIL flush_next_pair: got v%b %h/%h cnt %0d expected v1 AA/BB cnt 1", pair_valid, add1, add2, count);
    end
    pair_ready = 1'b1;
    cycle();
    pair_ready = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_final_pop: got %0d expected 0", count); end
  endtask

  task automatic test_async_reset();
    pair_ready = 1'b0;
    for (int b = 0; b < 5; b++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h61 + b);
      cycle();
    end
    in_valid = 1'b0;
    #1;
    n_checks++; if (count !== 3'd2 || half_held !== 1'b1 || add1 !== 8'h61) begin
      n_fail++; $display("FAIL arst_pre: got cnt %0d half %b add1 %h expected 2/1/61", count, half_held, add1);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0 || pair_valid !== 1'b0 || half_held !== 1'b0) begin
      n_fail++; $display("FAIL arst_immediate: got cnt %0d valid %b half %b expected 0/0/0", count, pair_valid, half_held);
    end
    n_checks++; if (add1 !== 8'h00 || add2 !== 8'h00 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL arst_outputs: got %h/%h ready %b expected 00/00 ready 1", add1, add2, in_ready);
    end
    cycle();
    rst_n = 1'b1;
    cycle();
    n_checks++; if (count !== 3'd0 || pair_valid !== 1'b0) begin n_fail++; $display("FAIL arst_after: got cnt %0d valid %b expected 0/0", count, pair_valid); end
  endtask

  initial begin
    rst_n      = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    pair_ready = 1'b0;
    test_reset();
    test_single_pair();
    test_fill_stall();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
